// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the DataMemory arbiter, its core/debug requesters and DataMemory.
// The c_lock/d_lock inputs exist only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ready;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_rdata;

    logic              busy;
    logic              grant_d;
`ifdef DMEM_ARB_LOCK_EN
    logic              c_lock;
    logic              d_lock;
`endif

    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  c_lock, d_lock,
`endif
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output c_ready, c_rvalid, c_rdata,
        output d_ready, d_rvalid, d_rdata,
        output m_addr, m_wdata, m_read, m_write,
        output busy, grant_d
    );

    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output c_lock, d_lock,
`endif
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  c_ready, c_rvalid, c_rdata,
        input  d_ready, d_rvalid, d_rdata,
        input  m_addr, m_wdata, m_read, m_write,
        input  busy, grant_d
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one DataMemory port between the core (C) and debug/DMA (D).
// Optional DMEM_ARB_LOCK_EN adds lock inputs allowing up to 4 consecutive grants to one port.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic          CLK,
    input  logic          resetl,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_last_d;
    logic              r_grant_d;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_c_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              w_any_req;
    logic              w_win_d;
    logic              w_start;
`ifdef DMEM_ARB_LOCK_EN
    logic              r_locked;
    logic [1:0]        r_lock_cnt;
    logic              w_relock;
`endif

    // A tie goes to the port that did not win last; a held lock overrides that until the count saturates.
    always_comb begin
        w_any_req = bus.c_req | bus.d_req;
        w_win_d   = (bus.c_req & bus.d_req) ? ~r_last_d : bus.d_req;
`ifdef DMEM_ARB_LOCK_EN
        w_relock  = r_locked & (r_grant_d ? bus.d_req : bus.c_req)
                  & ~((r_lock_cnt == 2'd3) & (r_grant_d ? bus.c_req : bus.d_req));
        if (w_relock) begin
            w_win_d = r_grant_d;
        end
`endif
        w_start   = (r_state == IDLE) & w_any_req;
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        bus.m_addr   = r_addr;
        bus.m_wdata  = r_wdata;
        bus.m_read   = 1'b0;
        bus.m_write  = 1'b0;
        bus.c_ready  = 1'b0;
        bus.c_rvalid = 1'b0;
        bus.d_ready  = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.c_rdata  = r_c_rdata;
        bus.d_rdata  = r_d_rdata;
        bus.busy     = (r_state != IDLE);
        bus.grant_d  = r_grant_d;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                // Gated by reset directly so a write in flight never commits once reset is seen.
                bus.m_read  = ~r_we & ~resetl;
                bus.m_write =  r_we & ~resetl;
                w_next      = RESP;
            end
            RESP: begin
                bus.c_ready  = ~r_grant_d;
                bus.c_rvalid = ~r_grant_d & ~r_we;
                bus.d_ready  =  r_grant_d;
                bus.d_rvalid =  r_grant_d & ~r_we;
                w_next       = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            r_last_d  <= 1'b1;
            r_grant_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_start) begin
                r_grant_d <= w_win_d;
                r_last_d  <= w_win_d;
                r_we      <= w_win_d ? bus.d_we    : bus.c_we;
                r_addr    <= w_win_d ? bus.d_addr  : bus.c_addr;
                r_wdata   <= w_win_d ? bus.d_wdata : bus.c_wdata;
            end
            if ((r_state == ISSUE) && !r_we) begin
                if (r_grant_d) begin
                    r_d_rdata <= bus.m_rdata;
                end else begin
                    r_c_rdata <= bus.m_rdata;
                end
            end
        end
    end

`ifdef DMEM_ARB_LOCK_EN
    // The owner's lock is only honoured in the IDLE cycle directly after its RESP.
    always_ff @(posedge CLK) begin
        if (resetl) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= 2'd0;
        end else begin
            r_locked <= (r_state == RESP) ? (r_grant_d ? bus.d_lock : bus.c_lock) : 1'b0;
            if (w_start) begin
                if (w_relock) begin
                    r_lock_cnt <= (r_lock_cnt == 2'd3) ? 2'd3 : r_lock_cnt + 2'd1;
                end else begin
                    r_lock_cnt <= 2'd0;
                end
            end
        end
    end
`endif
endmodule
